// File: rtl/phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module : phase_arbiter
// Round-robin green scheduler for a 4-approach intersection with latched walk.
// Rev    : 1.0
// ============================================================================
module phase_arbiter #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] car_req,
  input  logic       ped_btn,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic       walk,
  output logic [1:0] phase
);

  localparam int c_max_ab  = (MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN;
  localparam int c_max_cd  = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
  localparam int c_max_ce  = (c_max_cd > WALK) ? c_max_cd : WALK;
  localparam int c_max_all = (c_max_ab > c_max_ce) ? c_max_ab : c_max_ce;
  localparam int c_tw      = $clog2(c_max_all) + 1;

  localparam logic [c_tw-1:0] c_min_last  = c_tw'(MIN_GREEN - 1);
  localparam logic [c_tw-1:0] c_max_last  = c_tw'(MAX_GREEN - 1);
  localparam logic [c_tw-1:0] c_yel_last  = c_tw'(YELLOW - 1);
  localparam logic [c_tw-1:0] c_clr_last  = c_tw'(ALL_RED - 1);
  localparam logic [c_tw-1:0] c_walk_last = c_tw'(WALK - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_CLEAR  = 3'd3,
    S_WALK   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  state_t          w_d_state;
  logic [c_tw-1:0] r_timer;
  logic            r_ped_pend;
  logic [1:0]      w_next_phase;
  logic [1:0]      w_d_phase;
  logic [1:0]      w_rr_idx;
  logic            w_rr_found;
  logic            w_conflict;
  logic            w_green_exit;
  logic [3:0]      w_green_nxt;
  logic [3:0]      w_yellow_nxt;

  // Scan from phase+4 down to phase+1 so the nearest requester after phase wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = phase;
    for (int k = 4; k >= 1; k--) begin
      if (car_req[phase + 2'(k)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = phase + 2'(k);
      end
    end
  end

  assign w_d_state = r_ped_pend ? S_WALK : (w_rr_found ? S_GREEN : S_IDLE);
  assign w_d_phase = (!r_ped_pend && w_rr_found) ? w_rr_idx : phase;

  assign w_conflict   = r_ped_pend | (|(car_req & ~(4'b0001 << phase)));
  assign w_green_exit = w_conflict && (r_timer >= c_min_last) &&
                        (!car_req[phase] || (r_timer >= c_max_last));

  always_comb begin
    w_next       = r_state;
    w_next_phase = phase;
    case (r_state)
      S_IDLE: begin
        w_next       = w_d_state;
        w_next_phase = w_d_phase;
      end
      S_GREEN:  if (w_green_exit) w_next = S_YELLOW;
      S_YELLOW: if (r_timer == c_yel_last) w_next = S_CLEAR;
      S_CLEAR: begin
        if (r_timer == c_clr_last) begin
          w_next       = w_d_state;
          w_next_phase = w_d_phase;
        end
      end
      S_WALK:   if (r_timer == c_walk_last) w_next = S_CLEAR;
      default:  w_next = S_IDLE;
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  assign w_green_nxt  = (w_next == S_GREEN)  ? (4'b0001 << w_next_phase) : 4'b0000;
  assign w_yellow_nxt = (w_next == S_YELLOW) ? (4'b0001 << w_next_phase) : 4'b0000;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      phase      <= 2'd3;
      r_timer    <= '0;
      r_ped_pend <= 1'b0;
      green      <= 4'h0;
      yellow     <= 4'h0;
      red        <= 4'hF;
      walk       <= 1'b0;
    end else begin
      r_state <= w_next;
      phase   <= w_next_phase;
      if ((w_next != r_state) || (w_next == S_IDLE)) begin
        r_timer <= '0;
      end else if (!((r_state == S_GREEN) && (r_timer >= c_max_last))) begin
        r_timer <= r_timer + 1'b1;
      end
      // Entering WALK consumes the pending request even if the button is still held.
      r_ped_pend <= ((w_next == S_WALK) && (r_state != S_WALK)) ? 1'b0 : (r_ped_pend | ped_btn);
      green      <= w_green_nxt;
      yellow     <= w_yellow_nxt;
      red        <= ~(w_green_nxt | w_yellow_nxt);
      walk       <= (w_next == S_WALK);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_phase_arbiter
// Directed self-checking bench for phase_arbiter (default timing parameters).
// Rev    : 1.0
// ============================================================================
module tb_phase_arbiter;

  logic       clock;
  logic       reset_n;
  logic [3:0] car_req;
  logic       ped_btn;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic       walk;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  phase_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .car_req (car_req),
    .ped_btn (ped_btn),
    .green   (green),
    .yellow  (yellow),
    .red     (red),
    .walk    (walk),
    .phase   (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {walk, yellow, green, red}
  function automatic logic [12:0] lamps();
    return {walk, yellow, green, red};
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  // Counts how many samples the current lamp pattern persists; stops on the first new one.
  task automatic run_len(output int n);
    logic [12:0] cur;
    cur = lamps();
    n = 1;
    while (n < 200) begin
      step();
      if (lamps() != cur) break;
      n++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    car_req = 4'h0;
    ped_btn = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (lamps() !== {1'b0, 4'h0, 4'h0, 4'hF} || phase !== 2'd3) begin
      errors++;
      $display("FAIL reset_state: got lamps=%h phase=%0d expected lamps=%h phase=3",
               lamps(), phase, {1'b0, 4'h0, 4'h0, 4'hF});
    end
    car_req = 4'b0001;
    step();
    step();
    checks++;
    if (green !== 4'b0001) begin
      errors++;
      $display("FAIL reset_pre_green: got %b expected 0001", green);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (lamps() !== {1'b0, 4'h0, 4'h0, 4'hF} || phase !== 2'd3) begin
      errors++;
      $display("FAIL reset_async: got lamps=%h phase=%0d expected lamps=%h phase=3",
               lamps(), phase, {1'b0, 4'h0, 4'h0, 4'hF});
    end
    car_req = 4'h0;
    step();
    reset_n = 1'b1;
    repeat (5) step();
    checks++;
    if (lamps() !== {1'b0, 4'h0, 4'h0, 4'hF}) begin
      errors++;
      $display("FAIL reset_idle_after: got %h expected %h", lamps(), {1'b0, 4'h0, 4'h0, 4'hF});
    end
  endtask

  task automatic test_rest_in_green();
    int n;
    do_reset();
    car_req = 4'b0001;
    step();
    checks++;
    if (lamps() !== {1'b0, 4'h0, 4'b0001, 4'b1110} || phase !== 2'd0) begin
      errors++;
      $display("FAIL rest_first_green: got lamps=%h phase=%0d expected lamps=%h phase=0",
               lamps(), phase, {1'b0, 4'h0, 4'b0001, 4'b1110});
    end
    repeat (20) step();
    checks++;
    if (green !== 4'b0001) begin
      errors++;
      $display("FAIL rest_held: got %b expected 0001", green);
    end
    car_req = 4'b0000;
    repeat (10) step();
    checks++;
    if (green !== 4'b0001) begin
      errors++;
      $display("FAIL rest_dropped: got %b expected 0001", green);
    end
    car_req = 4'b0010;
    step();
    checks++;
    if (lamps() !== {1'b0, 4'b0001, 4'h0, 4'b1110}) begin
      errors++;
      $display("FAIL rest_to_yellow: got %h expected %h", lamps(), {1'b0, 4'b0001, 4'h0, 4'b1110});
    end
    run_len(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL rest_yellow_len: got %0d expected 3", n);
    end
    run_len(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL rest_allred_len: got %0d expected 1", n);
    end
    checks++;
    if (lamps() !== {1'b0, 4'h0, 4'b0010, 4'b1101} || phase !== 2'd1) begin
      errors++;
      $display("FAIL rest_next_green: got lamps=%h phase=%0d expected lamps=%h phase=1",
               lamps(), phase, {1'b0, 4'h0, 4'b0010, 4'b1101});
    end
  endtask

  task automatic test_max_green();
    int n;
    do_reset();
    car_req = 4'b0101;
    step();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] m;
      m = (i == 0) ? 4'b0001 : 4'b0100;
      checks++;
      if (lamps() !== {1'b0, 4'h0, m, ~m}) begin
        errors++;
        $display("FAIL max_green_lamp%0d: got %h expected %h", i, lamps(), {1'b0, 4'h0, m, ~m});
      end
      run_len(n);
      checks++;
      if (n !== 12) begin
        errors++;
        $display("FAIL max_green_len%0d: got %0d expected 12", i, n);
      end
      checks++;
      if (yellow !== m) begin
        errors++;
        $display("FAIL max_yellow%0d: got %b expected %b", i, yellow, m);
      end
      run_len(n);
      checks++;
      if (n !== 3) begin
        errors++;
        $display("FAIL max_yellow_len%0d: got %0d expected 3", i, n);
      end
      run_len(n);
      checks++;
      if (n !== 1) begin
        errors++;
        $display("FAIL max_allred_len%0d: got %0d expected 1", i, n);
      end
    end
    checks++;
    if (green !== 4'b0001) begin
      errors++;
      $display("FAIL max_wrap_green: got %b expected 0001", green);
    end
  endtask

  task automatic test_ped_walk();
    int n;
    do_reset();
    car_req = 4'b0001;
    step();
    step();
    ped_btn = 1'b1;
    step();
    ped_btn = 1'b0;
    car_req = 4'b0000;
    run_len(n);
    checks++;
    if (n + 2 !== 4) begin
      errors++;
      $display("FAIL ped_green_len: got %0d expected 4", n + 2);
    end
    run_len(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL ped_yellow_len: got %0d expected 3", n);
    end
    run_len(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL ped_allred_len: got %0d expected 1", n);
    end
    checks++;
    if (lamps() !== {1'b1, 4'h0, 4'h0, 4'hF} || dut.r_ped_pend !== 1'b0) begin
      errors++;
      $display("FAIL ped_walk_entry: got lamps=%h pend=%b expected lamps=%h pend=0",
               lamps(), dut.r_ped_pend, {1'b1, 4'h0, 4'h0, 4'hF});
    end
    car_req = 4'b0001;
    run_len(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL ped_walk_len: got %0d expected 6", n);
    end
    run_len(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL ped_post_walk_red: got %0d expected 1", n);
    end
    checks++;
    if (green !== 4'b0001 || phase !== 2'd0) begin
      errors++;
      $display("FAIL ped_resume_green: got green=%b phase=%0d expected 0001 phase=0", green, phase);
    end
  endtask

  task automatic test_own_drop();
    int n;
    do_reset();
    car_req = 4'b0011;
    step();
    step();
    car_req = 4'b0010;
    run_len(n);
    checks++;
    if (n + 1 !== 4) begin
      errors++;
      $display("FAIL own_drop_green_len: got %0d expected 4", n + 1);
    end
    checks++;
    if (yellow !== 4'b0001) begin
      errors++;
      $display("FAIL own_drop_yellow: got %b expected 0001", yellow);
    end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    car_req = 4'b1111;
    step();
    checks++;
    if (green !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first: got %b expected 0001", green);
    end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] m;
      logic [3:0] mn;
      m  = 4'b0001 << i;
      mn = 4'b0001 << ((i + 1) % 4);
      run_len(n);
      checks++;
      if (n !== 12) begin
        errors++;
        $display("FAIL rr_green_len%0d: got %0d expected 12", i, n);
      end
      checks++;
      if (yellow !== m) begin
        errors++;
        $display("FAIL rr_yellow%0d: got %b expected %b", i, yellow, m);
      end
      run_len(n);
      run_len(n);
      checks++;
      if (green !== mn) begin
        errors++;
        $display("FAIL rr_next%0d: got %b expected %b", i, green, mn);
      end
    end
  endtask

  task automatic test_back_to_back_walk();
    int n;
    // Green 0 is showing from the round-robin test; request a walk.
    ped_btn = 1'b1;
    step();
    ped_btn = 1'b0;
    run_len(n);
    run_len(n);
    run_len(n);
    checks++;
    if (walk !== 1'b1 || red !== 4'hF) begin
      errors++;
      $display("FAIL b2b_walk1: got walk=%b red=%h expected walk=1 red=F", walk, red);
    end
    step();
    ped_btn = 1'b1;
    step();
    ped_btn = 1'b0;
    run_len(n);
    checks++;
    if (n + 2 !== 6) begin
      errors++;
      $display("FAIL b2b_walk1_len: got %0d expected 6", n + 2);
    end
    run_len(n);
    checks++;
    if (lamps() !== {1'b1, 4'h0, 4'h0, 4'hF}) begin
      errors++;
      $display("FAIL b2b_walk2: got %h expected %h", lamps(), {1'b1, 4'h0, 4'h0, 4'hF});
    end
    run_len(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL b2b_walk2_len: got %0d expected 6", n);
    end
    run_len(n);
    checks++;
    if (green !== 4'b0010 || phase !== 2'd1) begin
      errors++;
      $display("FAIL b2b_resume: got green=%b phase=%0d expected 0010 phase=1", green, phase);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    car_req = 4'h0;
    ped_btn = 1'b0;
    test_reset();
    test_rest_in_green();
    test_max_green();
    test_ped_walk();
    test_own_drop();
    test_round_robin();
    test_back_to_back_walk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
